branch_predict_unit: RTL

//  Parametrised branch resolution plus dynamic prediction. The fetch side indexes a

---
 rtl/branch_predict_unit_pkg.sv | 27 ++
 rtl/branch_predict_unit_sat_counter2.sv | 21 ++
 rtl/branch_predict_unit.sv | 105 ++++++++++
 3 files changed

// File: rtl/branch_predict_unit_pkg.sv
// Shared encodings for the branch predict unit: BHT counter states, ALU compare codes
// and PC mux selects, plus a helper classifying conditional-branch compare codes.
package branch_predict_unit_pkg;

  localparam logic [1:0] BHT_SNT = 2'b00;
  localparam logic [1:0] BHT_WNT = 2'b01;
  localparam logic [1:0] BHT_WT  = 2'b10;
  localparam logic [1:0] BHT_ST  = 2'b11;

  localparam logic [2:0] ALU_CMP_EQ  = 3'b000;
  localparam logic [2:0] ALU_CMP_NE  = 3'b001;
  localparam logic [2:0] ALU_CMP_LT  = 3'b100;
  localparam logic [2:0] ALU_CMP_GE  = 3'b101;
  localparam logic [2:0] ALU_CMP_LTU = 3'b110;
  localparam logic [2:0] ALU_CMP_GEU = 3'b111;

  localparam logic [1:0] PC_MUX_PC4     = 2'b00;
  localparam logic [1:0] PC_MUX_BRANCH  = 2'b01;
  localparam logic [1:0] PC_MUX_ALU_OUT = 2'b10;

  function automatic logic is_cond_cmp(input logic [2:0] op);
    return (op == ALU_CMP_EQ)  || (op == ALU_CMP_NE)  ||
           (op == ALU_CMP_LT)  || (op == ALU_CMP_GE)  ||
           (op == ALU_CMP_LTU) || (op == ALU_CMP_GEU);
  endfunction

endpackage

// File: rtl/branch_predict_unit_sat_counter2.sv
// 2-bit saturating counter next-state: increments toward BHT_ST, decrements toward BHT_SNT.
module branch_predict_unit_sat_counter2
  import branch_predict_unit_pkg::*;
(
  input  logic [1:0] cur,
  input  logic       inc,
  input  logic       en,
  output logic [1:0] next
);

  always_comb begin
    next = cur;
    if (en) begin
      if (inc && (cur != BHT_ST))
        next = cur + 2'd1;
      else if (!inc && (cur != BHT_SNT))
        next = cur - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch resolution (EX) plus 2-bit BHT direction prediction (IF).
// Optional BRANCH_STATS_EN macro adds branch / mispredict event counters.
module branch_predict_unit
  import branch_predict_unit_pkg::*;
#(
  parameter int         XLEN      = 32,
  parameter int         BHT_DEPTH = 64,
  parameter logic [1:0] CTR_INIT  = 2'b01
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_valid,
  output logic            pred_taken,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [2:0]      ex_cmp_opcode,
  input  logic [XLEN-1:0] ex_alu_result,
  input  logic            ex_pc_jump,
  input  logic            ex_pred_taken,
`ifdef BRANCH_STATS_EN
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts,
`endif
  output logic [1:0]      branch,
  output logic            mispredict
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  logic [1:0]       bht [BHT_DEPTH];
  logic [IDX_W-1:0] if_idx, ex_idx;
  logic             zero, lt, taken, cond;
  logic [1:0]       upd_next, look_ctr;
  logic             unused_pc_bits;

  assign if_idx = if_pc[IDX_W+1:2];
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign unused_pc_bits = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0],
                            ex_pc[XLEN-1:IDX_W+2], ex_pc[1:0]};

  // EX stage: resolve direction from the ALU compare result
  assign zero = (ex_alu_result == '0);
  assign lt   = ex_alu_result[0];

  always_comb begin
    taken = 1'b0;
    case (ex_cmp_opcode)
      ALU_CMP_EQ:  taken = zero;
      ALU_CMP_NE:  taken = ~zero;
      ALU_CMP_LT:  taken = lt;
      ALU_CMP_LTU: taken = lt;
      ALU_CMP_GE:  taken = ~lt;
      ALU_CMP_GEU: taken = ~lt;
      default:     taken = 1'b0;
    endcase
  end

  assign cond       = ex_valid & ~ex_pc_jump & is_cond_cmp(ex_cmp_opcode);
  assign branch     = ex_pc_jump ? PC_MUX_ALU_OUT : {1'b0, cond & taken};
  assign mispredict = cond & (taken != ex_pred_taken);

  branch_predict_unit_sat_counter2 u_ctr (
    .cur  (bht[ex_idx]),
    .inc  (taken),
    .en   (cond),
    .next (upd_next)
  );

  // Lookup sees the post-update counter when EX trains the same entry this cycle
  assign look_ctr = (cond && (ex_idx == if_idx)) ? upd_next : bht[if_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= CTR_INIT;
    end else if (cond) begin
      bht[ex_idx] <= upd_next;
    end
  end

  // IF stage boundary: registered prediction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pred_valid <= 1'b0;
      pred_taken <= 1'b0;
    end else begin
      pred_valid <= if_valid;
      pred_taken <= if_valid ? look_ctr[1] : 1'b0;
    end
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      stat_branches    <= stat_branches + {31'd0, cond};
      stat_mispredicts <= stat_mispredicts + {31'd0, mispredict};
    end
  end
`endif

endmodule
